data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the multi-cycle CPU. Accepts load/store requests issued by the control FSM over the mem_en/mem_wen/addr/wdata interface, models a configurable-latency synchronous RAM, and returns rdata with a one-cycle mem_ready pulse. Sits between the control unit / datapath and the data storage array. The control unit holds its EXECUTE/WRITEBACK state until mem_ready.

## Interface
- DATA_W, 32: data word width.
- ADDR_W, 10: word-address width.
- DEPTH, 1024: number of words; must be a power of two ≤ 2^ADDR_W when MEM_RANGE_CHECK_EN is undefined.
- WAIT_STATES, 2: extra access cycles, 0..15.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_en  in  1  request valid; held by requester until mem_ready.
- mem_wen  in  1  1 = store, 0 = load; meaningful only with mem_en.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load result; registered.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- fault  out  1  out-of-range flag, valid with mem_ready (only with MEM_RANGE_CHECK_EN; otherwise tied 0).

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: on mem_en=1, latch addr, wdata, mem_wen into internal regs; load wait counter with WAIT_STATES; next WAIT, or ACCESS if WAIT_STATES=0.
- WAIT: counter decrements each cycle; when it reaches 1, next ACCESS.
- ACCESS: store writes latched wdata to array[latched addr] at the ending edge; load registers array[latched addr] into rdata. Next RESP.
- RESP: mem_ready=1 for exactly one cycle; next IDLE unconditionally.
- Inputs are ignored outside IDLE; there is no queueing. A change of addr/wdata during service has no effect.
- rdata changes only at the end of a load ACCESS; stores and idle cycles keep the previous value.
- Array contents are not reset. Index = low log2(DEPTH) bits of addr.

## Timing
- Reset (reset=0, asynchronous): state IDLE, rdata=0, mem_ready=0, busy=0, fault=0, counter=0.
- Request sampled in cycle 0 (IDLE) → WAIT cycles 1..N → ACCESS cycle N+1 → mem_ready high in cycle N+2. Latency is N+2 cycles; with N=0 it is 2.
- Store commits at the rising edge that ends ACCESS; it is visible to a load accepted in any later IDLE.
- Back-to-back: if mem_en is still high in the IDLE cycle after RESP, it is accepted as a new request. The requester must drop mem_en in the cycle after mem_ready unless it is issuing a new request.
- Reset asserted before the ACCESS-ending edge: the pending store is discarded and no mem_ready is produced. Reset asserted in RESP: the pulse is cut short; the array keeps the committed write.
- busy rises the cycle after acceptance and falls the cycle after RESP.

## Configuration
- MEM_RANGE_CHECK_EN defined: a request with latched addr ≥ DEPTH is not written and does not read the array. On a load, rdata is forced to 0. fault=1 with mem_ready in RESP and is 0 in every other cycle. Latency is unchanged.
- Undefined: no check and no fault logic; fault is tied 0 and the address wraps modulo DEPTH.

## Test plan
- Reset: drive reset=0 mid-WAIT during a store of 0xDEADBEEF to addr 5, then reload addr 5 → rdata equals the pre-reset contents; all outputs were 0 during reset.
- WAIT_STATES=2: store 0x12345678 @ 3, then load @ 3 → mem_ready at request+4 in both cases; rdata=0x12345678 and unchanged after a following store.
- WAIT_STATES=0: back-to-back loads of @ 1 and @ 2 with mem_en held → two mem_ready pulses exactly 3 cycles apart (2-cycle latency plus the re-accept IDLE cycle); correct data each time.
- Mid-service noise: change addr/wdata/mem_wen during WAIT → the operation uses the values latched at acceptance.
- MEM_RANGE_CHECK_EN, DEPTH=512: store 0xFFFF_FFFF @ 600 → fault=1 with mem_ready; array @ 88 untouched. Load @ 600 → rdata=0, fault=1.
- Macro undefined, DEPTH=512: store @ 600 → load @ 88 returns the stored value; fault stays 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the multi-cycle CPU.
// Accepts one load/store at a time, spends WAIT_STATES extra cycles before
// touching the array, then pulses mem_ready for one cycle.
// Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range requests skip the
// array, loads return 0 and fault is raised alongside mem_ready).
module data_mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic              wen_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              hit;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept    = (state == S_IDLE) && mem_en;
  assign mem_ready = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) ACCESS -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (mem_en) begin
          state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the request at acceptance and count down the wait states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      wen_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_STATES);
      wen_q    <= mem_wen;
      idx_q    <= addr[IDX_W-1:0];
      wdata_q  <= wdata;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic oob_q;

  // Flag a request whose full address lies beyond the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_q <= 1'b0;
    end else if (accept) begin
      oob_q <= ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
    end
  end

  assign hit   = !oob_q;
  assign fault = (state == S_RESP) && oob_q;
`else
  logic unused_addr_hi;

  // Address wraps modulo DEPTH; upper address bits are intentionally ignored.
  assign unused_addr_hi = ^addr;
  assign hit            = 1'b1;
  assign fault          = 1'b0;
`endif

  // Storage array (not reset): a store commits at the edge that ends ACCESS.
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && wen_q && hit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Load result register: only a load ACCESS updates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if ((state == S_ACCESS) && !wen_q) begin
      rdata <= hit ? mem[idx_q] : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: u0 uses 2 wait states / 1024 words,
// u1 uses 0 wait states / 512 words. Expectations are queued when a request
// is issued and checked when mem_ready appears.
module tb_data_mem_responder;

  localparam int DW = 32;
  localparam int AW = 10;
`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          en0, wen0, rdy0, busy0, fault0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          en1, wen1, rdy1, busy1, fault1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .WAIT_STATES(2)) u0 (
    .clk(clk), .reset(reset), .mem_en(en0), .mem_wen(wen0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .mem_ready(rdy0), .busy(busy0), .fault(fault0)
  );

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .WAIT_STATES(0)) u1 (
    .clk(clk), .reset(reset), .mem_en(en1), .mem_wen(wen1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .mem_ready(rdy1), .busy(busy1), .fault(fault1)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          fault;
    int            req_cyc;
  } exp_t;

  typedef struct {
    bit            d;
    bit            wen;
    int            a;
    logic [DW-1:0] wd;
    logic [DW-1:0] er;
    logic          ef;
    bit            noise;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   rdy_cyc1[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   done0 = 0;
  int   done1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input bit d, input logic en, input logic wen,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (!d) begin
      en0 = en; wen0 = wen; addr0 = a; wdata0 = wd;
    end else begin
      en1 = en; wen1 = wen; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic push_exp(input bit d, input logic [DW-1:0] er, input logic ef);
    exp_t e;
    e.rdata   = er;
    e.fault   = ef;
    e.req_cyc = cyc;
    if (d) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic issue(input vec_t v);
    int start;
    bit got;
    logic [AW-1:0] a;
    a = v.a[AW-1:0];
    @(posedge clk); #1;
    drive(v.d, 1'b1, v.wen, a, v.wd);
    push_exp(v.d, v.er, v.ef);
    start = v.d ? done1 : done0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        check($sformatf("u%0d_busy_rise", v.d), v.d ? busy1 : busy0, 1'b1);
        if (v.noise) drive(v.d, 1'b1, ~v.wen, a ^ 10'h2A5, ~v.wd);
      end
      if ((v.d ? done1 : done0) > start) got = 1'b1;
    end
    check($sformatf("u%0d_ready_seen_a%0d", v.d, v.a), got, 1'b1);
    check($sformatf("u%0d_busy_fall", v.d), v.d ? busy1 : busy0, 1'b0);
    drive(v.d, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    bit got;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // u0: 2 wait states, 1024 words
    tbl.push_back('{1'b0, 1'b1,    3, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0,    3, 32'h0,         32'h1234_5678, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1,    7, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0,    7, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1,    5, 32'hA5A5_0005, 32'hCAFE_F00D, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0,    5, 32'h0,         32'hA5A5_0005, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1,    9, 32'h9999_0009, 32'hA5A5_0005, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0,    9, 32'h0,         32'h9999_0009, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1023, 32'h003F_F3FF, 32'h9999_0009, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1023, 32'h0,         32'h003F_F3FF, 1'b0, 1'b0});
    // u1: 0 wait states, 512 words
    tbl.push_back('{1'b1, 1'b1,    1, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1,    2, 32'h2222_2222, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1,   88, 32'h0000_0088, 32'h0000_0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0,   88, 32'h0,         32'h0000_0088, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1,  600, 32'hFFFF_FFFF, 32'h0000_0088, RC,   1'b0});
    tbl.push_back('{1'b1, 1'b0,   88, 32'h0, (RC ? 32'h0000_0088 : 32'hFFFF_FFFF), 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0,  600, 32'h0, (RC ? 32'h0000_0000 : 32'hFFFF_FFFF), RC,   1'b0});

    repeat (3) @(posedge clk); #1;
    check("rst_rdata0", rdata0, '0);
    check("rst_ready0", rdy0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_fault0", fault0, 1'b0);
    check("rst_rdata1", rdata1, '0);
    check("rst_ready1", rdy1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_fault1", fault1, 1'b0);
    reset = 1'b1;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rdy0 === 1'b1) begin
            if (q0.size() == 0) check("u0_spurious_ready", rdy0, 1'b0);
            else begin
              e = q0.pop_front();
              check("u0_rdata", rdata0, e.rdata);
              check("u0_fault", fault0, e.fault);
              check("u0_latency", cyc - e.req_cyc, 4);
              done0++;
            end
          end else check("u0_fault_idle", fault0, 1'b0);
          if (rdy1 === 1'b1) begin
            rdy_cyc1.push_back(cyc);
            if (q1.size() == 0) check("u1_spurious_ready", rdy1, 1'b0);
            else begin
              e = q1.pop_front();
              check("u1_rdata", rdata1, e.rdata);
              check("u1_fault", fault1, e.fault);
              check("u1_latency", cyc - e.req_cyc, 2);
              done1++;
            end
          end else check("u1_fault_idle", fault1, 1'b0);
        end
      end
    join_none

    foreach (tbl[i]) issue(tbl[i]);

    // Back-to-back loads on u1 with mem_en held across the re-accept IDLE cycle.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 10'd1, '0);
    push_exp(1'b1, 32'h1111_1111, 1'b0);
    s = done1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (done1 > s) got = 1'b1;
    end
    check("b2b_first_ready", got, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 10'd2, '0);
    push_exp(1'b1, 32'h2222_2222, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (done1 > s + 1) got = 1'b1;
    end
    check("b2b_second_ready", got, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    n = rdy_cyc1.size();
    if (n >= 2) check("b2b_pulse_gap", rdy_cyc1[n-1] - rdy_cyc1[n-2], 3);
    else check("b2b_pulse_count", n, 2);

    // Reset during WAIT of a store to @5: store is discarded, outputs clear.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("rst_mid_busy_before", busy0, 1'b1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_mid_rdata0", rdata0, '0);
    check("rst_mid_ready0", rdy0, 1'b0);
    check("rst_mid_busy0", busy0, 1'b0);
    check("rst_mid_fault0", fault0, 1'b0);
    check("rst_mid_rdata1", rdata1, '0);
    check("rst_mid_busy1", busy1, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("rst_hold_rdata0", rdata0, '0);
    check("rst_hold_busy0", busy0, 1'b0);
    reset = 1'b1;
    issue('{1'b0, 1'b0, 5, 32'h0, 32'hA5A5_0005, 1'b0, 1'b0});

    repeat (5) @(posedge clk); #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
